// File: rtl/seq_mon_pkg.sv
// Shared types, code constants and transition-relation helpers for the sequencer monitor.
package seq_mon_pkg;

    localparam int unsigned CODE_W = 3;
    localparam int unsigned HOLD_W = 8;

    typedef enum logic [1:0] {IDLE, TRACK, FAIL} state_t;

    localparam logic [CODE_W-1:0] C_S0 = 3'd0;
    localparam logic [CODE_W-1:0] C_S2 = 3'd2;
    localparam logic [CODE_W-1:0] C_S6 = 3'd6;
    localparam logic [CODE_W-1:0] C_S3 = 3'd3;
    localparam logic [CODE_W-1:0] C_S7 = 3'd7;

    // Self-loops are always legal; otherwise only the ring steps and 3->7.
    function automatic logic legal_step(input logic [CODE_W-1:0] prev,
                                        input logic [CODE_W-1:0] code);
        legal_step = (prev == code)
                   || (prev == C_S0 && code == C_S2)
                   || (prev == C_S2 && code == C_S6)
                   || (prev == C_S6 && code == C_S0)
                   || (prev == C_S3 && code == C_S7);
    endfunction

    function automatic logic is_ring(input logic [CODE_W-1:0] code);
        is_ring = (code == C_S0) || (code == C_S2) || (code == C_S6);
    endfunction

    function automatic logic is_bad(input logic [CODE_W-1:0] code);
        is_bad = code[2] & code[0];
    endfunction

endpackage

// File: rtl/seq_monitor_if.sv
// Observed code stream plus the monitor's verdict outputs.
interface seq_monitor_if
    import seq_mon_pkg::*;
#(
    parameter int unsigned LAP_W = 8
);
    logic              valid;
    logic [CODE_W-1:0] code;
    logic              armed;
    logic              trans_err;
    logic              bad_err;
    logic              stall_err;
    logic [CODE_W-1:0] err_prev;
    logic [CODE_W-1:0] err_code;
    logic [LAP_W-1:0]  laps;

    modport master (
        output valid, code,
        input  armed, trans_err, bad_err, stall_err, err_prev, err_code, laps
    );

    modport slave (
        input  valid, code,
        output armed, trans_err, bad_err, stall_err, err_prev, err_code, laps
    );
endinterface

// File: rtl/seq_monitor_sat_counter.sv
// Saturating up-counter with synchronous clear; never wraps.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);
    localparam logic [W-1:0] CNT_MAX = '1;

    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && count != CNT_MAX) begin
            count <= count + W'(1);
        end
    end
endmodule

// File: rtl/seq_monitor.sv
// Passive checker of a 3-bit sequencer state stream against its legal transition relation.
module seq_monitor
    import seq_mon_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4,
    parameter int unsigned LAP_W    = 8
) (
    input  logic clk,
    input  logic reset,
    seq_monitor_if.slave mon
);
    state_t            state, state_nx;
    logic [CODE_W-1:0] prev, prev_nx;
    logic              armed_nx, trans_nx, bad_nx, stall_nx;
    logic [CODE_W-1:0] err_prev_nx, err_code_nx;
    logic              lap_inc, hold_clr, hold_inc;
    logic [HOLD_W-1:0] hold_cnt;
    logic [LAP_W-1:0]  laps_q;
    logic              same;

    assign same     = (mon.code == prev);
    assign mon.laps = laps_q;

    // State and registered verdict outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            prev          <= '0;
            mon.armed     <= 1'b0;
            mon.trans_err <= 1'b0;
            mon.bad_err   <= 1'b0;
            mon.stall_err <= 1'b0;
            mon.err_prev  <= '0;
            mon.err_code  <= '0;
        end else begin
            state         <= state_nx;
            prev          <= prev_nx;
            mon.armed     <= armed_nx;
            mon.trans_err <= trans_nx;
            mon.bad_err   <= bad_nx;
            mon.stall_err <= stall_nx;
            mon.err_prev  <= err_prev_nx;
            mon.err_code  <= err_code_nx;
        end
    end

    // Next-state and flag logic; nothing moves without valid.
    always_comb begin
        state_nx    = state;
        prev_nx     = prev;
        armed_nx    = mon.armed;
        trans_nx    = mon.trans_err;
        bad_nx      = mon.bad_err;
        stall_nx    = mon.stall_err;
        err_prev_nx = mon.err_prev;
        err_code_nx = mon.err_code;
        lap_inc     = 1'b0;
        hold_clr    = 1'b0;
        hold_inc    = 1'b0;

        if (mon.valid) begin
            prev_nx  = mon.code;
            hold_clr = !same;
            hold_inc = same;
            if (is_bad(mon.code)) begin
                bad_nx = 1'b1;
            end
            // This repeat pushes hold_cnt past MAX_HOLD.
            if (same && is_ring(mon.code) && hold_cnt >= HOLD_W'(MAX_HOLD)) begin
                stall_nx = 1'b1;
            end

            case (state)
                IDLE: begin
                    if (mon.code == C_S0) begin
                        state_nx = TRACK;
                        armed_nx = 1'b1;
                    end else begin
                        state_nx    = FAIL;
                        trans_nx    = 1'b1;
                        err_prev_nx = C_S0;
                        err_code_nx = mon.code;
                    end
                end
                TRACK: begin
                    if (legal_step(prev, mon.code)) begin
                        lap_inc = (prev == C_S6) && (mon.code == C_S0);
                    end else begin
                        state_nx    = FAIL;
                        trans_nx    = 1'b1;
                        err_prev_nx = prev;
                        err_code_nx = mon.code;
                    end
                end
                FAIL: begin
                    state_nx = FAIL;
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    sat_counter #(.W(LAP_W)) u_laps (
        .clk   (clk),
        .reset (reset),
        .clr   (1'b0),
        .inc   (lap_inc),
        .count (laps_q)
    );

    sat_counter #(.W(HOLD_W)) u_hold (
        .clk   (clk),
        .reset (reset),
        .clr   (hold_clr),
        .inc   (hold_inc),
        .count (hold_cnt)
    );
endmodule

// File: tb/tb_seq_monitor.sv
// Directed bench for seq_monitor: two instances (LAP_W=8 and LAP_W=2) share one stimulus stream.
module tb_seq_monitor;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    seq_monitor_if #(.LAP_W(8)) mif ();
    seq_monitor_if #(.LAP_W(2)) mif2 ();

    seq_monitor #(.MAX_HOLD(4), .LAP_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .mon   (mif)
    );

    seq_monitor #(.MAX_HOLD(4), .LAP_W(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .mon   (mif2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic [2:0] c);
        mif.valid  = v;
        mif.code   = c;
        mif2.valid = v;
        mif2.code  = c;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step(1'b0, 3'd0);
        reset = 1'b1;
    endtask

    task automatic check_clear(input string tag);
        check({tag, "_armed"}, 32'(mif.armed), 32'd0);
        check({tag, "_trans"}, 32'(mif.trans_err), 32'd0);
        check({tag, "_bad"}, 32'(mif.bad_err), 32'd0);
        check({tag, "_stall"}, 32'(mif.stall_err), 32'd0);
        check({tag, "_eprev"}, 32'(mif.err_prev), 32'd0);
        check({tag, "_ecode"}, 32'(mif.err_code), 32'd0);
        check({tag, "_laps"}, 32'(mif.laps), 32'd0);
        check({tag, "_laps2"}, 32'(mif2.laps), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        reset      = 1'b0;
        mif.valid  = 1'b0;
        mif.code   = 3'd0;
        mif2.valid = 1'b0;
        mif2.code  = 3'd0;
        @(posedge clk);
        #1;

        // 1: clean ring, two laps
        do_reset();
        check_clear("t1_rst");
        step(1'b1, 3'd0);
        check("t1_armed", 32'(mif.armed), 32'd1);
        step(1'b1, 3'd2); step(1'b1, 3'd6); step(1'b1, 3'd0);
        check("t1_lap1", 32'(mif.laps), 32'd1);
        step(1'b1, 3'd2); step(1'b1, 3'd6); step(1'b1, 3'd0);
        check("t1_laps", 32'(mif.laps), 32'd2);
        check("t1_laps2", 32'(mif2.laps), 32'd2);
        check("t1_trans", 32'(mif.trans_err), 32'd0);
        check("t1_bad", 32'(mif.bad_err), 32'd0);
        check("t1_stall", 32'(mif.stall_err), 32'd0);

        // 2: illegal 2->4
        do_reset();
        step(1'b1, 3'd0); step(1'b1, 3'd2);
        check("t2_pre_trans", 32'(mif.trans_err), 32'd0);
        step(1'b1, 3'd4);
        check("t2_trans", 32'(mif.trans_err), 32'd1);
        check("t2_eprev", 32'(mif.err_prev), 32'd2);
        check("t2_ecode", 32'(mif.err_code), 32'd4);
        check("t2_laps", 32'(mif.laps), 32'd0);
        check("t2_bad", 32'(mif.bad_err), 32'd0);
        check("t2_armed", 32'(mif.armed), 32'd1);

        // 3: illegal first code, then bad code, then repeated absorbing 7s
        do_reset();
        step(1'b1, 3'd3);
        check("t3_trans", 32'(mif.trans_err), 32'd1);
        check("t3_eprev", 32'(mif.err_prev), 32'd0);
        check("t3_ecode", 32'(mif.err_code), 32'd3);
        check("t3_armed", 32'(mif.armed), 32'd0);
        check("t3_nobad", 32'(mif.bad_err), 32'd0);
        step(1'b1, 3'd7);
        check("t3_bad", 32'(mif.bad_err), 32'd1);
        check("t3_ecode_hold", 32'(mif.err_code), 32'd3);
        for (int i = 0; i < 7; i++) step(1'b1, 3'd7);
        check("t3_stall7", 32'(mif.stall_err), 32'd0);

        // 4: stall on 2 held six samples
        do_reset();
        step(1'b1, 3'd0);
        for (int i = 0; i < 5; i++) step(1'b1, 3'd2);
        check("t4_stall_early", 32'(mif.stall_err), 32'd0);
        step(1'b1, 3'd2);
        check("t4_stall", 32'(mif.stall_err), 32'd1);
        check("t4_trans", 32'(mif.trans_err), 32'd0);

        // 5: invalid gaps carrying junk codes are ignored
        do_reset();
        step(1'b1, 3'd0); step(1'b0, 3'd5); step(1'b1, 3'd2); step(1'b0, 3'd4);
        step(1'b1, 3'd6); step(1'b1, 3'd0); step(1'b0, 3'd7); step(1'b1, 3'd2);
        step(1'b0, 3'd1); step(1'b1, 3'd6); step(1'b1, 3'd0);
        check("t5_laps", 32'(mif.laps), 32'd2);
        check("t5_trans", 32'(mif.trans_err), 32'd0);
        check("t5_bad", 32'(mif.bad_err), 32'd0);
        check("t5_stall", 32'(mif.stall_err), 32'd0);

        // 6: error then reset mid-stream (reset beats a valid bad code), then saturation
        do_reset();
        step(1'b1, 3'd0); step(1'b1, 3'd2); step(1'b1, 3'd5);
        check("t6_trans", 32'(mif.trans_err), 32'd1);
        check("t6_bad", 32'(mif.bad_err), 32'd1);
        reset = 1'b0;
        step(1'b1, 3'd5);
        reset = 1'b1;
        check_clear("t6_rst");
        step(1'b1, 3'd0); step(1'b1, 3'd2); step(1'b1, 3'd6); step(1'b1, 3'd0);
        check("t6_lap1", 32'(mif.laps), 32'd1);
        check("t6_armed", 32'(mif.armed), 32'd1);
        check("t6_clean", 32'(mif.trans_err), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 3'd2); step(1'b1, 3'd6); step(1'b1, 3'd0);
        end
        check("t6_laps5", 32'(mif.laps), 32'd5);
        check("t6_laps_sat", 32'(mif2.laps), 32'd3);
        check("t6_end_trans", 32'(mif.trans_err), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/seq_monitor.md
Name: seq_monitor

Overview:
Passive checker that receives a 3-bit state-code stream from a sequencer and checks it against the legal transition relation.
- Legal relation: 0->2->6->0 ring; 3->7; codes 1, 4, 5 and 7 are absorbing.
- Flags illegal transitions, the bad condition (code[2] & code[0]), and stalls longer than MAX_HOLD samples.
- Counts completed ring laps.
- Sits beside the sequencer as its observer; outputs feed the property and assertion harness.

Parameters:
MAX_HOLD, 4, max consecutive valid samples one ring code (0/2/6) may repeat before stall_err; legal range 1..255.
LAP_W, 8, width of lap counter (saturating).

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-low reset
valid  input  1  code is sampled this cycle
code  input  3  observed sequencer state
armed  output  1  first sample accepted, monitor tracking
trans_err  output  1  sticky: illegal transition seen
bad_err  output  1  sticky: code 5 or 7 sampled
stall_err  output  1  sticky: ring code held > MAX_HOLD samples
err_prev  output  3  code before first illegal transition
err_code  output  3  code at first illegal transition
laps  output  LAP_W  completed 6->0 transitions, saturating

Behaviour:
Reset:
- Clocked by clk; reset is synchronous, active-low.
- While reset==0 at a clk edge: FSM=IDLE; all outputs 0; prev=0; hold_cnt=0.
- Reset wins over valid in the same cycle; reset mid-stream discards all history.

FSM states: IDLE, TRACK, FAIL.
- IDLE:
  - valid & code==0: store prev=0, go TRACK, armed=1 next cycle.
  - valid & code!=0: trans_err=1, err_prev=0, err_code=code, go FAIL.
  - The reset image of the sequencer is 0, so any other first code is illegal.
- TRACK, on each valid sample, judge the pair (prev, code):
  - Legal: 0->2, 2->6, 6->0, 3->7, and x->x for every x.
  - Illegal: anything else. Set trans_err and capture err_prev/err_code in the same edge, then go FAIL.
  - Legal: update prev=code.
- FAIL:
  - Latched error state; err_prev/err_code frozen.
  - armed stays 1 if it was already 1.
  - Only reset exits.
  - bad_err and stall_err keep evaluating (FAIL still updates prev on valid).
- valid==0: no state, prev, or counter change in any state.

bad_err:
- Set on the edge after any valid sample with code[2]&code[0] (5 or 7), in any FSM state including IDLE.
- Sticky until reset.

Hold counter:
- hold_cnt is 8-bit, saturating at 255.
- Cleared on a valid sample whose code differs from prev; incremented on a valid sample equal to prev.
- stall_err sets when a valid repeat of a ring code (0, 2, 6) makes hold_cnt exceed MAX_HOLD. Absorbing codes never raise stall_err.

Laps:
- Increments on a legal 6->0 sample in TRACK.
- Saturates at 2^LAP_W-1; no wrap.
- Does not count in IDLE or FAIL.

Simultaneity:
- One sample can set trans_err and bad_err together; e.g. 2->5 sets both on the same edge.
- All outputs are registered; every flag appears 1 cycle after the offending sample.
- Latency is exactly 1 clk.

Decomposition:
- Package seq_mon_pkg holds:
  - state enum {IDLE, TRACK, FAIL};
  - code constants C_S0=0, C_S2=2, C_S6=6, C_S3=3, C_S7=7;
  - function legal_step(prev, code).
- One sub-module: sat_counter (parameterised width, inc, clr, saturating). Instantiated twice: laps and hold_cnt.

Test Plan:
1. Reset, then valid codes 0,2,6,0,2,6,0 on consecutive cycles -> armed=1 after the first sample; laps=2; all error flags 0.
2. Codes 0,2,4 -> trans_err=1 the cycle after 4; err_prev=2, err_code=4; laps stays 0; bad_err=0.
3. First code after reset = 3 -> trans_err=1, err_prev=0, err_code=3. Then code 7 -> bad_err=1 next cycle; err_code stays 3.
4. With MAX_HOLD=4: code 2 repeated 6 valid samples after 0 -> stall_err rises one cycle after the 6th 2 (hold_cnt=5), not earlier. Repeated 7s never raise it.
5. valid toggled 0/1 within the ring sequence -> invalid cycles ignored; laps identical to the gap-free run.
6. Drive an error, then reset=0 for 1 cycle mid-stream -> all outputs 0 next cycle. A new sequence starting at 0 is tracked cleanly. LAP_W=2 with 5 laps -> laps=3 (saturated).
